rtype_exec: RTL and testbench
=============================

# rtype_exec

Multi-cycle decode/execute/write-back stage that consumes 32-bit MIPS instruction words from the fetch stage (PC register + instruction ROM) and executes MIPS-I R-type ALU instructions against a local 32×32 register file. Instructions arrive over a valid/ready handshake. Each accepted instruction walks a 4-state FSM and produces a write-back strobe, a result and status flags. A debug port preloads and inspects registers for bring-up and verification.

## Interface
- No parameters. Widths are fixed at MIPS-I values: 32-bit data, 5-bit register address.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
- inst_valid  input  1  fetch stage presents a valid instruction
- inst_code  input  32  instruction word
- inst_ready  output  1  stage can accept an instruction; high only in IDLE with reset high
- wb_valid  output  1  one-cycle pulse: a register write-back occurred
- wb_addr  output  5  destination register of the last write-back
- wb_data  output  32  value of the last write-back
- zf  output  1  last ALU result was zero
- of  output  1  signed overflow on the last add/sub
- err  output  1  last instruction was illegal, or trapped on overflow
- dbg_we  input  1  debug register write enable
- dbg_addr  input  5  debug read/write address
- dbg_wdata  input  32  debug write data
- dbg_rdata  output  32  combinational read of rf[dbg_addr]; 0 for address 0

## Operation
- FSM states are IDLE, DECODE, EXEC and WB. Each state lasts exactly one cycle except IDLE.
- IDLE: inst_ready=1. On inst_valid&&inst_ready, latch inst_code and go to DECODE. Otherwise stay in IDLE.
- DECODE: latch A=rf[rs] (bits 25:21), B=rf[rt] (bits 20:16), rd (15:11) and shamt (10:6). Go to EXEC.
- EXEC: compute the result and latch it, along with zf, of and err. Go to WB.
- WB: write rf[rd] unless suppressed, and pulse wb_valid unless suppressed. Go to IDLE.
- Legal instructions have opcode (31:26)=0 and one of these funct values (5:0):
  - 0x20 add: A+B
  - 0x22 sub: A-B
  - 0x24 and
  - 0x25 or
  - 0x26 xor
  - 0x27 nor
  - 0x2A slt: signed compare, result is 1 or 0
  - 0x00 sll: B<<shamt
  - 0x02 srl: B>>shamt, logical
- All arithmetic is modulo 2^32.
- of is set only for add/sub, as signed two's-complement overflow; it is 0 for every other funct.
- Illegal instruction (any other opcode or funct): err=1, no register write, no wb_valid. The FSM still passes through all states.
- rd=0: wb_valid pulses with wb_addr=0, but rf[0] stays 0. dbg_rdata for address 0 is always 0.
- Register file: reset clears all 32 entries.
- Debug write: dbg_we writes rf[dbg_addr] at the clock edge only when the FSM is in IDLE and no handshake is accepted on that edge. It is ignored in any other state, and ignored for address 0.
- zf, of, err, wb_addr and wb_data hold their values until the next EXEC or WB update.

## Timing
- Reset (reset=0 at a rising edge) forces:
  - state=IDLE
  - all register-file entries = 0
  - wb_valid=0, wb_addr=0, wb_data=0, zf=0, of=0, err=0
- inst_ready is 0 while reset is low.
- Instruction accepted at edge k:
  - operands latched at k+1
  - result and flags latched at k+2
  - register write, wb_valid=1, wb_addr and wb_data updated at k+3
  - wb_valid deasserts at k+4
- inst_ready returns high after edge k+3, so the next accept is at edge k+4 at the earliest. Throughput is one instruction per 4 cycles.
- No RAW hazard exists: a write at k+3 always precedes the next operand read at k+5 or later.
- Reset low in any state aborts the instruction: no write-back, no wb_valid.
- inst_code changing while not in IDLE is ignored.

## Configuration
- OVERFLOW_TRAP_EN defined: add/sub with signed overflow sets of=1 and err=1, suppresses the register write, and suppresses wb_valid.
- OVERFLOW_TRAP_EN undefined: the wrapped result is written and wb_valid pulses; of=1 and err=0.

## Test plan
- Add: dbg writes r1=5, r2=3; send 0x00221820 (add r3,r1,r2).
  - wb_valid high exactly 3 edges after accept, wb_addr=3, wb_data=8, zf=0.
  - dbg_rdata for address 3 reads 8.
- Sub, then back-to-back: send 0x00412022 (sub r4,r2,r1) immediately after the add.
  - inst_ready is low for 3 cycles between the two instructions.
  - Sub result r4=0xFFFFFFFE, of=0.
- Overflow: dbg writes r1=0x7FFFFFFF, r2=1; send 0x00221820.
  - With OVERFLOW_TRAP_EN: err=1, of=1, no wb_valid, r3 keeps its prior value.
  - Without it: r3=0x80000000, of=1, err=0.
- Shift: with r2=3, send 0x00023100 (sll r6,r2,4).
  - r6=0x30.
  - Then srl of the same register by 4 returns 0x3.
- Illegal instruction: send 0x8C220000 (lw).
  - err=1, no wb_valid, register file unchanged, inst_ready high again 3 cycles after accept.
- rd=0 and reset: add with rd=0 pulses wb_valid, but address 0 still reads 0.
  - Separately, drive reset low while the FSM is in EXEC: no wb_valid, all registers read 0, inst_ready=1 on the first cycle after reset goes high.

Source files
------------

// File: rtl/rtype_exec.sv
// rtype_exec: multi-cycle decode/execute/write-back stage for MIPS-I R-type
// ALU instructions, with a local 32x32 register file and a debug port.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   inst_valid/ready  instruction handshake (ready high only in IDLE)
//   inst_code         32-bit instruction word
//   wb_valid          one-cycle write-back strobe
//   wb_addr/wb_data   destination and value of the last write-back
//   zf, of, err       zero, signed overflow, illegal/trap status
//   dbg_we/addr/wdata debug register write (IDLE only, r0 ignored)
//   dbg_rdata         combinational debug read, 0 for r0
//
// Build option: define OVERFLOW_TRAP_EN to trap add/sub signed overflow
// (err=1, write-back suppressed). Default: wrapped result is written.
module rtype_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst_code,
  output logic        inst_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        zf,
  output logic        of,
  output logic        err,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  state_e         state_q;
  logic [DW-1:0]  rf_q [NREG];
  logic [DW-1:0]  ir_q;
  logic [DW-1:0]  a_q, b_q;
  logic [AW-1:0]  rd_q, shamt_q;
  logic [DW-1:0]  res_q;
  logic           wb_valid_q, zf_q, of_q, err_q;
  logic [AW-1:0]  wb_addr_q;
  logic [DW-1:0]  wb_data_q;

  logic [DW-1:0]  res_d, sum_d, diff_d;
  logic           of_d, err_d, illegal_d;

  // ALU: evaluated from the latched operands during EXEC
  always_comb begin
    res_d     = '0;
    of_d      = 1'b0;
    illegal_d = 1'b0;
    sum_d     = a_q + b_q;
    diff_d    = a_q - b_q;
    if (ir_q[31:26] != 6'd0) begin
      illegal_d = 1'b1;
    end else begin
      case (ir_q[5:0])
        6'h20: begin
          res_d = sum_d;
          of_d  = (a_q[DW-1] == b_q[DW-1]) && (sum_d[DW-1] != a_q[DW-1]);
        end
        6'h22: begin
          res_d = diff_d;
          of_d  = (a_q[DW-1] != b_q[DW-1]) && (diff_d[DW-1] != a_q[DW-1]);
        end
        6'h24:   res_d = a_q & b_q;
        6'h25:   res_d = a_q | b_q;
        6'h26:   res_d = a_q ^ b_q;
        6'h27:   res_d = ~(a_q | b_q);
        6'h2A:   res_d = DW'($signed(a_q) < $signed(b_q));
        6'h00:   res_d = b_q << shamt_q;
        6'h02:   res_d = b_q >> shamt_q;
        default: illegal_d = 1'b1;
      endcase
    end
`ifdef OVERFLOW_TRAP_EN
    err_d = illegal_d | of_d;
`else
    err_d = illegal_d;
`endif
  end

  // FSM, register file and registered status in one sequential block
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      shamt_q    <= '0;
      res_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      zf_q       <= 1'b0;
      of_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inst_valid) begin
            ir_q    <= inst_code;
            state_q <= S_DECODE;
          end else if (dbg_we && (dbg_addr != '0)) begin
            // debug writes only land on idle edges with no accept
            rf_q[dbg_addr] <= dbg_wdata;
          end
        end
        S_DECODE: begin
          a_q     <= rf_q[ir_q[25:21]];
          b_q     <= rf_q[ir_q[20:16]];
          rd_q    <= ir_q[15:11];
          shamt_q <= ir_q[10:6];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= res_d;
          zf_q    <= (res_d == '0);
          of_q    <= of_d;
          err_q   <= err_d;
          state_q <= S_WB;
        end
        S_WB: begin
          // err covers both illegal opcodes and trapped overflow
          if (!err_q) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_q;
            wb_data_q  <= res_q;
            if (rd_q != '0) rf_q[rd_q] <= res_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_ready = (state_q == S_IDLE) && reset;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign zf         = zf_q;
  assign of         = of_q;
  assign err        = err_q;
  assign dbg_rdata  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_rtype_exec.sv
// Directed testbench for rtype_exec.
module tb_rtype_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic        inst_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        zf, of, err;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  rtype_exec dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_code  (inst_code),
    .inst_ready (inst_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .zf         (zf),
    .of         (of),
    .err        (err),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int rs, input int rt, input int rd,
                                      input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  // One cycle spent in IDLE to read a register through the debug port
  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    @(posedge clk); #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  // Accept one instruction, check the 3 busy cycles and the write-back edge
  task automatic run(input logic [31:0] code, input logic exp_wb);
    int n = 0;
    while (!inst_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_accept", 32'(inst_ready), 32'd1);
    inst_valid = 1'b1; inst_code = code;
    @(posedge clk); #1;
    inst_valid = 1'b0; inst_code = $urandom;
    for (int c = 0; c < 3; c++) begin
      check("ready_low_busy", 32'(inst_ready), 32'd0);
      check("wb_low_busy", 32'(wb_valid), 32'd0);
      inst_code = $urandom;
      @(posedge clk); #1;
    end
    check("wb_valid_k3", 32'(wb_valid), 32'(exp_wb));
    check("ready_k3", 32'(inst_ready), 32'd1);
  endtask

  logic [31:0] tcode [8];
  logic [31:0] tres  [8];
  logic [4:0]  trd   [8];

  initial begin
    reset = 1'b0; inst_valid = 1'b0; inst_code = '0;
    dbg_we = 1'b1; dbg_addr = 5'd1; dbg_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_flags", {29'd0, zf, of, err}, 32'd0);
    check("rst_ready_low", 32'(inst_ready), 32'd0);
    check("rst_r1", dbg_rdata, 32'd0);
    dbg_we = 1'b0;
    reset = 1'b1;
    #1;
    check("ready_after_rst", 32'(inst_ready), 32'd1);

    // add r3,r1,r2 then sub r4,r2,r1 back-to-back
    dbg_wr(5'd1, 32'd5);
    dbg_wr(5'd2, 32'd3);
    run(32'h0022_1820, 1'b1);
    check("add_addr", 32'(wb_addr), 32'd3);
    check("add_data", wb_data, 32'd8);
    check("add_zf", 32'(zf), 32'd0);
    run(32'h0041_2022, 1'b1);
    check("sub_addr", 32'(wb_addr), 32'd4);
    check("sub_data", wb_data, 32'hFFFF_FFFE);
    check("sub_of", 32'(of), 32'd0);
    chk_reg("r3_add", 5'd3, 32'd8);
    chk_reg("r4_sub", 5'd4, 32'hFFFF_FFFE);

    // logic, compare and shift table (r1=5, r2=3, r4=-2)
    tcode[0] = enc(1, 2, 5, 0, 'h24); tres[0] = 32'd1;          trd[0] = 5'd5;
    tcode[1] = enc(1, 2, 5, 0, 'h25); tres[1] = 32'd7;          trd[1] = 5'd5;
    tcode[2] = enc(1, 2, 5, 0, 'h26); tres[2] = 32'd6;          trd[2] = 5'd5;
    tcode[3] = enc(1, 2, 5, 0, 'h27); tres[3] = 32'hFFFF_FFF8;  trd[3] = 5'd5;
    tcode[4] = enc(4, 1, 5, 0, 'h2A); tres[4] = 32'd1;          trd[4] = 5'd5;
    tcode[5] = enc(1, 4, 5, 0, 'h2A); tres[5] = 32'd0;          trd[5] = 5'd5;
    tcode[6] = 32'h0002_3100;         tres[6] = 32'h30;         trd[6] = 5'd6;
    tcode[7] = enc(0, 6, 7, 4, 'h02); tres[7] = 32'h3;          trd[7] = 5'd7;
    for (int i = 0; i < 8; i++) begin
      run(tcode[i], 1'b1);
      check($sformatf("tbl%0d_addr", i), 32'(wb_addr), 32'(trd[i]));
      check($sformatf("tbl%0d_data", i), wb_data, tres[i]);
      check($sformatf("tbl%0d_zf", i), 32'(zf), 32'(tres[i] == 32'd0));
      check($sformatf("tbl%0d_of_err", i), {30'd0, of, err}, 32'd0);
    end
    run(enc(0, 1, 8, 31, 'h00), 1'b1);
    check("sll31", wb_data, 32'h8000_0000);
    run(enc(0, 4, 8, 31, 'h02), 1'b1);
    check("srl31_logical", wb_data, 32'd1);
    chk_reg("r6_sll", 5'd6, 32'h30);

    // illegal: lw and an unsupported funct
    run(32'h8C22_0000, 1'b0);
    check("lw_err", 32'(err), 32'd1);
    check("lw_wb_data_held", wb_data, 32'd1);
    chk_reg("lw_r1", 5'd1, 32'd5);
    chk_reg("lw_r2", 5'd2, 32'd3);
    run(enc(1, 2, 5, 0, 'h21), 1'b0);
    check("funct_err", 32'(err), 32'd1);
    chk_reg("funct_r5", 5'd5, 32'd0);

    // rd=0 write-back and ignored debug write to r0
    dbg_wr(5'd0, 32'hDEAD_BEEF);
    run(enc(1, 2, 0, 0, 'h20), 1'b1);
    check("rd0_addr", 32'(wb_addr), 32'd0);
    check("rd0_data", wb_data, 32'd8);
    check("rd0_err_clear", 32'(err), 32'd0);
    chk_reg("rd0_r0", 5'd0, 32'd0);

    // debug write held high across accept and busy states is ignored
    inst_valid = 1'b1; inst_code = enc(1, 2, 11, 0, 'h25);
    dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'h1234;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dbg_we = 1'b0;
    check("busy_wb", 32'(wb_valid), 32'd1);
    chk_reg("busy_dbg_r10", 5'd10, 32'd0);
    chk_reg("busy_r11", 5'd11, 32'd7);

    // signed overflow on add and sub
    dbg_wr(5'd1, 32'h7FFF_FFFF);
    dbg_wr(5'd2, 32'd1);
    dbg_wr(5'd8, 32'h8000_0000);
`ifdef OVERFLOW_TRAP_EN
    run(32'h0022_1820, 1'b0);
    check("ovf_add_of", 32'(of), 32'd1);
    check("ovf_add_err", 32'(err), 32'd1);
    chk_reg("ovf_add_r3", 5'd3, 32'd8);
    run(enc(8, 2, 9, 0, 'h22), 1'b0);
    check("ovf_sub_flags", {30'd0, of, err}, 32'd3);
    chk_reg("ovf_sub_r9", 5'd9, 32'd0);
`else
    run(32'h0022_1820, 1'b1);
    check("ovf_add_data", wb_data, 32'h8000_0000);
    check("ovf_add_flags", {30'd0, of, err}, 32'd2);
    chk_reg("ovf_add_r3", 5'd3, 32'h8000_0000);
    run(enc(8, 2, 9, 0, 'h22), 1'b1);
    check("ovf_sub_flags", {30'd0, of, err}, 32'd2);
    chk_reg("ovf_sub_r9", 5'd9, 32'h7FFF_FFFF);
`endif
    run(enc(2, 2, 12, 0, 'h20), 1'b1);
    check("noovf_flags", {30'd0, of, err}, 32'd0);

    // reset asserted while in EXEC aborts the instruction
    inst_valid = 1'b1; inst_code = enc(1, 2, 13, 0, 'h25);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_exec_ready", 32'(inst_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_exec_wb", 32'(wb_valid), 32'd0);
    end
    reset = 1'b1;
    #1;
    check("rst_exec_ready_hi", 32'(inst_ready), 32'd1);
    check("rst_exec_wb_data", wb_data, 32'd0);
    chk_reg("rst_exec_r1", 5'd1, 32'd0);
    chk_reg("rst_exec_r13", 5'd13, 32'd0);
    check("rst_exec_wb_after", 32'(wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
